// File: rtl/mux_rr_fifo_n.sv
// N-lane buffered multiplexer: one DEPTH-entry FIFO per lane, drained by a
// round-robin or fixed-priority arbiter into a registered, backpressured output.
module mux_rr_fifo_n #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  localparam int CW   = $clog2(N),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] data_in,
  input  logic [N-1:0]   valid_in,
  output logic [N-1:0]   in_full,
  output logic [N-1:0]   err_overflow,
  output logic [W-1:0]   data_out,
  output logic           valid_out,
  output logic [CW-1:0]  ch_out,
  input  logic           ready_out
);

  logic [W-1:0]  mem     [N][DEPTH];
  logic [AW-1:0] wr_ptr  [N];
  logic [AW-1:0] rd_ptr  [N];
  logic [AW:0]   cnt     [N];
  logic [AW:0]   cnt_nxt [N];
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant;
  logic          any_ne;
  logic          slot_free;
  logic          pop_en;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;

  // Arbitration: scan from lowest priority to highest so the last hit wins.
  always_comb begin
    grant  = '0;
    any_ne = 1'b0;
    if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cnt[i] != '0) begin
          grant  = CW'(i);
          any_ne = 1'b1;
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (cnt[(int'(last_grant) + k) % N] != '0) begin
          grant  = CW'((int'(last_grant) + k) % N);
          any_ne = 1'b1;
        end
      end
    end
  end

  assign slot_free = ~valid_out | ready_out;
  assign pop_en    = slot_free & any_ne;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      push[i]    = valid_in[i] & ~in_full[i];
      pop[i]     = pop_en & (grant == CW'(i));
      cnt_nxt[i] = cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    end
  end

  // Stage p0: lane FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= data_in[i*W +: W];
    end
  end

  // Stage p1: FIFO bookkeeping and the registered output slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      in_full      <= '0;
      err_overflow <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      ch_out       <= '0;
      last_grant   <= CW'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        cnt[i]          <= cnt_nxt[i];
        in_full[i]      <= (cnt_nxt[i] == (AW+1)'(DEPTH));
        err_overflow[i] <= err_overflow[i] | (valid_in[i] & in_full[i]);
      end
      if (pop_en) begin
        data_out  <= mem[grant][rd_ptr[grant]];
        ch_out    <= grant;
        valid_out <= 1'b1;
        if (MODE == 0) last_grant <= grant;
      end else if (slot_free) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_fifo_n.sv
// Scoreboard bench for mux_rr_fifo_n: a round-robin and a fixed-priority
// instance, each with an expected-output queue drained by its own monitor.
module tb_mux_rr_fifo_n;
  localparam int W = 8;
  localparam int N = 4;
  localparam int DEPTH = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   valid_in = '0;
  logic [N-1:0]   valid_in_fp = '0;
  logic           ready_out = 1'b0;

  logic [N-1:0]  rr_full, rr_err, fp_full, fp_err;
  logic [W-1:0]  rr_data, fp_data;
  logic          rr_valid, fp_valid;
  logic [CW-1:0] rr_ch, fp_ch;

  logic [CW+W-1:0] q_rr[$];
  logic [CW+W-1:0] q_fp[$];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_rr_fifo_n #(.W(W), .N(N), .DEPTH(DEPTH), .MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .in_full(rr_full), .err_overflow(rr_err), .data_out(rr_data),
    .valid_out(rr_valid), .ch_out(rr_ch), .ready_out(ready_out));

  mux_rr_fifo_n #(.W(W), .N(N), .DEPTH(DEPTH), .MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in_fp),
    .in_full(fp_full), .err_overflow(fp_err), .data_out(fp_data),
    .valid_out(fp_valid), .ch_out(fp_ch), .ready_out(ready_out));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitors: a transfer happens on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!reset && rr_valid && ready_out) begin
      if (q_rr.size() == 0) begin
        n_checks++;
        $display("FAIL rr_unexpected: got ch=%0d data=%h, expected no output", rr_ch, rr_data);
      end else begin
        check("rr_out", 32'({rr_ch, rr_data}), 32'(q_rr.pop_front()));
      end
    end
    if (!reset && fp_valid && ready_out) begin
      if (q_fp.size() == 0) begin
        n_checks++;
        $display("FAIL fp_unexpected: got ch=%0d data=%h, expected no output", fp_ch, fp_data);
      end else begin
        check("fp_out", 32'({fp_ch, fp_data}), 32'(q_fp.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    valid_in = '0;
    valid_in_fp = '0;
    ready_out = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain_check(input string name);
    check({name, "_rr_left"}, 32'(q_rr.size()), 32'd0);
    check({name, "_fp_left"}, 32'(q_fp.size()), 32'd0);
    q_rr.delete();
    q_fp.delete();
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(rr_data), 32'h0);
    check("rst_valid", 32'(rr_valid), 32'h0);
    check("rst_ch", 32'(rr_ch), 32'h0);
    check("rst_full", 32'(rr_full), 32'h0);
    check("rst_err", 32'(rr_err), 32'h0);
    reset = 1'b0;

    // Single word latency
    ready_out = 1'b1;
    data_in[0 +: W] = 8'h11;
    valid_in = 4'b0001;
    q_rr.push_back({2'd0, 8'h11});
    tick();
    valid_in = '0;
    check("t1_no_bypass", 32'(rr_valid), 32'h0);
    tick();
    check("t1_data", 32'(rr_data), 32'h11);
    check("t1_ch", 32'(rr_ch), 32'h0);
    check("t1_valid", 32'(rr_valid), 32'h1);
    repeat (3) tick();
    drain_check("t1");

    // Two words per lane on both instances: RR interleaves, FP drains by index
    apply_reset();
    ready_out = 1'b1;
    for (int j = 0; j < 2; j++)
      for (int l = 0; l < N; l++) q_rr.push_back({CW'(l), 8'(l * 16 + j)});
    for (int l = 0; l < N; l++)
      for (int j = 0; j < 2; j++) q_fp.push_back({CW'(l), 8'(l * 16 + j)});
    for (int j = 0; j < 2; j++) begin
      for (int l = 0; l < N; l++) data_in[l*W +: W] = 8'(l * 16 + j);
      valid_in = 4'hF;
      valid_in_fp = 4'hF;
      tick();
    end
    valid_in = '0;
    valid_in_fp = '0;
    repeat (10) tick();
    check("t2_rr_idle", 32'(rr_valid), 32'h0);
    check("t3_fp_idle", 32'(fp_valid), 32'h0);
    drain_check("t23");

    // Backpressure fills lane 2, sixth write overflows
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      data_in[2*W +: W] = 8'(8'hA0 + k);
      valid_in = 4'b0100;
      tick();
    end
    check("t4_full", 32'(rr_full), 32'h4);
    check("t4_hold_data", 32'(rr_data), 32'hA0);
    check("t4_hold_valid", 32'(rr_valid), 32'h1);
    check("t4_hold_ch", 32'(rr_ch), 32'h2);
    check("t4_no_err_yet", 32'(rr_err), 32'h0);
    data_in[2*W +: W] = 8'hA5;
    tick();
    valid_in = '0;
    check("t4_err", 32'(rr_err), 32'h4);
    check("t4_still_a0", 32'(rr_data), 32'hA0);
    for (int k = 0; k < 5; k++) q_rr.push_back({2'd2, 8'(8'hA0 + k)});
    ready_out = 1'b1;
    repeat (8) tick();
    check("t4_err_sticky", 32'(rr_err), 32'h4);
    check("t4_full_clear", 32'(rr_full), 32'h0);
    check("t4_idle", 32'(rr_valid), 32'h0);
    drain_check("t4");

    // Write to full lane 1 on the same edge as a pop is dropped
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      data_in[1*W +: W] = 8'(8'hB0 + k);
      valid_in = 4'b0010;
      tick();
    end
    check("t5_full", 32'(rr_full), 32'h2);
    for (int k = 0; k < 5; k++) q_rr.push_back({2'd1, 8'(8'hB0 + k)});
    ready_out = 1'b1;
    data_in[1*W +: W] = 8'hBF;
    tick();
    valid_in = '0;
    check("t5_err", 32'(rr_err), 32'h2);
    check("t5_full_after_pop", 32'(rr_full), 32'h0);
    repeat (8) tick();
    check("t5_idle", 32'(rr_valid), 32'h0);
    drain_check("t5");

    // Asynchronous reset mid-operation discards everything
    apply_reset();
    data_in = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    valid_in = 4'b1110;
    tick();
    data_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    tick();
    valid_in = '0;
    check("t6_pre_valid", 32'(rr_valid), 32'h1);
    check("t6_pre_data", 32'(rr_data), 32'hC1);
    check("t6_pre_ch", 32'(rr_ch), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_data", 32'(rr_data), 32'h0);
    check("t6_async_valid", 32'(rr_valid), 32'h0);
    check("t6_async_ch", 32'(rr_ch), 32'h0);
    check("t6_async_full", 32'(rr_full), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_out = 1'b1;
    repeat (10) tick();
    check("t6_no_stale", 32'(rr_valid), 32'h0);
    drain_check("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
